// File: rtl/usb_tx_scheduler.sv
// Round-robin owner of the single ULPI transmit path: grants one source, latches its
// frame, launches it once the bus is not turned around, and reports done/err to the owner.
module usb_tx_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned FRAME_W = 528,
  parameter int unsigned TIMEOUT = 2048
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] frame_in,
  input  logic                       dir,
  input  logic                       stp,
  output logic                       shift_out,
  output logic [FRAME_W-1:0]         frame_out,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT_STP,
    COOLDOWN
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               shift_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic [FRAME_W-1:0] frame_q;

  logic [IDX_W-1:0]   sel_d;
  logic               sel_vld_d;
  logic [IDX_W:0]     sum;
  logic [FRAME_W-1:0] frames [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign frames[g] = frame_in[g*FRAME_W +: FRAME_W];
  end

  // First requester at or after the rr pointer, wrapping past the last source.
  always_comb begin
    sel_d     = '0;
    sel_vld_d = 1'b0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!sel_vld_d && req[sum[IDX_W-1:0]]) begin
        sel_d     = sum[IDX_W-1:0];
        sel_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      frame_q <= '0;
    end else begin
      shift_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (sel_vld_d) begin
            grant_q <= NUM_REQ'(1) << sel_d;
            owner_q <= sel_d;
            frame_q <= frames[sel_d];
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!dir) begin
            shift_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= LAUNCH;
          end
        end
        // Counter runs from the launch cycle so the abort lands TIMEOUT cycles after shift_out.
        LAUNCH: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= WAIT_STP;
        end
        WAIT_STP: begin
          if (stp) begin
            done_q  <= NUM_REQ'(1) << owner_q;
            grant_q <= '0;
            state_q <= COOLDOWN;
          end else if (cnt_q >= CNT_LAST) begin
            err_q   <= NUM_REQ'(1) << owner_q;
            grant_q <= '0;
            state_q <= COOLDOWN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COOLDOWN: begin
          busy_q  <= 1'b0;
          rr_q    <= (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shift_out = shift_q;
  assign frame_out = frame_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: stimulus queues expected launch/done/err events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_usb_tx_scheduler;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned FRAME_W = 528;
  localparam int unsigned TIMEOUT = 2048;
  localparam int unsigned K_LAUNCH = 0, K_DONE = 1, K_ERR = 2;

  logic clk = 1'b0;
  logic n_rst, dir, stp, shift_out, busy;
  logic [NUM_REQ-1:0] req, grant, done, err;
  logic [NUM_REQ*FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] frame_out, fr0, fr1, old_fr;

  typedef struct {
    int unsigned        kind;
    logic [NUM_REQ-1:0] vec;
    logic [FRAME_W-1:0] frame;
  } ev_t;
  ev_t sb[$];

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  logic prev_shift = 1'b0;

  assign frame_in = {fr1, fr0};

  usb_tx_scheduler #(
    .NUM_REQ(NUM_REQ),
    .FRAME_W(FRAME_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req      (req),
    .frame_in (frame_in),
    .dir      (dir),
    .stp      (stp),
    .shift_out(shift_out),
    .frame_out(frame_out),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int i = 0; i < (FRAME_W + 31) / 32; i++) f = {f[FRAME_W-33:0], $urandom()};
    return f;
  endfunction

  task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned kind, input logic [NUM_REQ-1:0] vec, input logic [FRAME_W-1:0] frame);
    ev_t e;
    e.kind = kind; e.vec = vec; e.frame = frame;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int unsigned kind, input logic [NUM_REQ-1:0] vec);
    ev_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d vec %b, expected no event", kind, vec);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.vec !== vec || e.frame !== frame_out) begin
      n_err++;
      $display("FAIL event: got kind %0d vec %b frame %h, expected kind %0d vec %b frame %h",
               kind, vec, frame_out, e.kind, e.vec, e.frame);
    end
  endtask

  // Monitor: every launch/done/err the DUT shows is matched against the queue head.
  always @(negedge clk) begin
    if (n_rst) begin
      if (shift_out) begin
        chk("shift_out_width", prev_shift, 1'b0);
        expect_ev(K_LAUNCH, grant);
      end
      if (|done) expect_ev(K_DONE, done);
      if (|err)  expect_ev(K_ERR, err);
    end
    prev_shift = shift_out;
  end

  task automatic wait_launch(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (shift_out) begin
        at = cyc;
        break;
      end
    end
  endtask

  // stp is sampled n cycles after the negedge this is called on; done must follow next cycle.
  task automatic finish_xfer(input string name, input logic [NUM_REQ-1:0] expv, input int n, input logic drop);
    repeat (n - 1) @(negedge clk);
    stp = 1'b1;
    @(negedge clk);
    stp = 1'b0;
    chk({name, "_done"}, done, expv);
    chk({name, "_grant_clr"}, grant, '0);
    if (drop) req = '0;
    @(negedge clk);
    chk({name, "_done_pulse"}, done, '0);
    chk({name, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    int at, t0, te, seen;
    logic [NUM_REQ-1:0] v;
    n_rst = 1'b0; req = '0; dir = 1'b0; stp = 1'b0;
    fr0 = rnd_frame(); fr1 = rnd_frame();
    repeat (3) @(negedge clk);
    chk("rst_shift", shift_out, 1'b0);
    chk("rst_grant", grant, '0);
    chk("rst_done", done, '0);
    chk("rst_err", err, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame", frame_out, '0);
    n_rst = 1'b1;
    @(negedge clk);

    // stp while idle must not produce a done.
    stp = 1'b1; @(negedge clk); stp = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_stp_busy", busy, 1'b0);

    // Two held requests alternate starting at source 0.
    for (int k = 0; k < 4; k++) begin
      v = (k % 2 == 0) ? 2'b01 : 2'b10;
      push(K_LAUNCH, v, (k % 2 == 0) ? fr0 : fr1);
      push(K_DONE,   v, (k % 2 == 0) ? fr0 : fr1);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_launch(10, at);
      chk("rr_launched", at != -1, 1'b1);
      finish_xfer("rr", (k % 2 == 0) ? 2'b01 : 2'b10, 5 + k, k == 3);
    end

    // Single source, minimum latency, stp 100 cycles after launch.
    push(K_LAUNCH, 2'b01, fr0);
    push(K_DONE, 2'b01, fr0);
    req = 2'b01; t0 = cyc;
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_frame", frame_out, fr0);
    chk("t1_busy", busy, 1'b1);
    wait_launch(10, at);
    chk("t1_latency", at - t0, 2);
    finish_xfer("t1", 2'b01, 100, 1'b1);

    // Source 1 with the PHY holding dir high for 50 cycles.
    dir = 1'b1;
    push(K_LAUNCH, 2'b10, fr1);
    push(K_DONE, 2'b10, fr1);
    req = 2'b10;
    @(negedge clk);
    chk("t3_grant", grant, 2'b10);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (shift_out) seen++;
    end
    chk("t3_held_off", seen, 0);
    chk("t3_grant_kept", grant, 2'b10);
    dir = 1'b0; t0 = cyc;
    wait_launch(3, at);
    chk("t3_release_lat", at - t0, 1);
    finish_xfer("t3", 2'b10, 7, 1'b1);

    // No stp: abort exactly TIMEOUT cycles after launch.
    push(K_LAUNCH, 2'b01, fr0);
    push(K_ERR, 2'b01, fr0);
    req = 2'b01;
    wait_launch(10, at);
    te = -1;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (|err) begin
        te = cyc;
        break;
      end
    end
    chk("t4_err_time", te - at, TIMEOUT);
    chk("t4_done_clear", done, '0);
    req = '0;
    @(negedge clk);
    chk("t4_err_pulse", err, '0);
    chk("t4_busy_low", busy, 1'b0);

    // Request dropped after grant and source frame changed mid-transfer.
    old_fr = fr0;
    push(K_LAUNCH, 2'b01, old_fr);
    push(K_DONE, 2'b01, old_fr);
    req = 2'b01;
    @(negedge clk);
    chk("t5_grant", grant, 2'b01);
    repeat (2) @(negedge clk);
    req = '0;
    fr0 = rnd_frame();
    repeat (8) @(negedge clk);
    chk("t5_frame_hold", frame_out, old_fr);
    finish_xfer("t5", 2'b01, 1, 1'b0);

    // Reset in WAIT_STP with rr pointing at source 1; afterwards source 0 wins again.
    push(K_LAUNCH, 2'b01, fr0);
    req = 2'b01;
    wait_launch(10, at);
    chk("t6_launched", at != -1, 1'b1);
    repeat (5) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_shift", shift_out, 1'b0);
    chk("t6_rst_grant", grant, '0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_frame", frame_out, '0);
    chk("t6_rst_done", done | err, '0);
    sb.delete();
    req = '0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    push(K_LAUNCH, 2'b01, fr0);
    push(K_DONE, 2'b01, fr0);
    req = 2'b11;
    @(negedge clk);
    chk("t6_grant_src0", grant, 2'b01);
    wait_launch(10, at);
    chk("t6_relaunched", at != -1, 1'b1);
    finish_xfer("t6", 2'b01, 4, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
